tetris_matrix_scan: RTL

//  Consumer side of the playfield row-read channel. Walks rows 0..AREA_ROW-1, drives the row address,

---
 rtl/tetris_disp_pkg.sv | 22 ++
 rtl/tetris_row_shifter.sv | 83 ++++++++
 rtl/tetris_matrix_scan.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tetris_disp_pkg.sv
// Shared definitions for the LED-matrix display path: scan states, cell codes and a counter-width helper.
package tetris_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_HOLD
  } scan_state_e;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_FIXED  = 2'b01;
  localparam logic [1:0] CELL_MOVING = 2'b10;
  localparam logic [1:0] CELL_SPARE  = 2'b11;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tetris_row_shifter.sv
// Serialises one captured row word onto the LED driver, most significant cell first,
// with led_sclk generated from a SCLK_HALF clock divider.
module tetris_row_shifter
  import tetris_disp_pkg::*;
#(
  parameter int AREA_COL  = 16,
  parameter int SCLK_HALF = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  load_i,
  input  logic [AREA_COL*2-1:0] data_i,
  output logic [1:0]            sdo_o,
  output logic                  sclk_o,
  output logic                  done_o
);

  localparam int WORD_W = AREA_COL * 2;
  localparam int HALVES = AREA_COL * 2;
  localparam int HALF_W = cnt_width(HALVES);
  localparam int DIV_W  = cnt_width(SCLK_HALF);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              active_q, active_d;
  logic              sclk_q, sclk_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              half_end;
  logic              last_half;

  assign half_end  = active_q && (div_q == DIV_W'(SCLK_HALF - 1));
  assign last_half = (half_q == HALF_W'(HALVES - 1));
  assign done_o    = half_end && last_half;
  assign sdo_o     = sreg_q[WORD_W-1 -: 2];
  assign sclk_o    = sclk_q;

  // The word only advances when sclk falls, so sdo is stable across every rising edge.
  always_comb begin
    sreg_d   = sreg_q;
    active_d = active_q;
    sclk_d   = sclk_q;
    half_d   = half_q;
    div_d    = div_q;
    if (load_i) begin
      sreg_d   = data_i;
      active_d = 1'b1;
      sclk_d   = 1'b0;
      half_d   = '0;
      div_d    = '0;
    end else if (half_end) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      if (last_half) begin
        active_d = 1'b0;
        half_d   = '0;
      end else begin
        half_d = half_q + 1'b1;
        if (sclk_q) begin
          sreg_d = sreg_q << 2;
        end
      end
    end else if (active_q) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sreg_q   <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      half_q   <= '0;
      div_q    <= '0;
    end else begin
      sreg_q   <= sreg_d;
      active_q <= active_d;
      sclk_q   <= sclk_d;
      half_q   <= half_d;
      div_q    <= div_d;
    end
  end

endmodule

// File: rtl/tetris_matrix_scan.sv
// Row scanner for the playfield LED matrix: fetches each row, shifts it out, latches it and
// displays it for a fixed hold time, looping over the frame while enable is high.
module tetris_matrix_scan
  import tetris_disp_pkg::*;
#(
  parameter int AREA_ROW    = 32,
  parameter int AREA_COL    = 16,
  parameter int ROW_ADDR_W  = 5,
  parameter int SCLK_HALF   = 2,
  parameter int HOLD_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  output logic [ROW_ADDR_W-1:0] rd_row,
  input  logic [AREA_COL*2-1:0] rd_data,
  output logic [1:0]            led_sdo,
  output logic                  led_sclk,
  output logic                  led_latch,
  output logic [ROW_ADDR_W-1:0] led_row,
  output logic                  led_oe_n,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);

  scan_state_e           state_q, state_d;
  logic                  fetch2_q, fetch2_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [ROW_ADDR_W-1:0] row_q, row_d;
  logic [ROW_ADDR_W-1:0] led_row_q, led_row_d;
  logic                  frame_done_q, frame_done_d;
  logic                  shift_load;
  logic                  shift_done;
  logic                  hold_last;
  logic                  row_last;

  assign hold_last  = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign row_last   = (row_q == ROW_ADDR_W'(AREA_ROW - 1));
  assign rd_row     = row_q;
  assign led_row    = led_row_q;
  assign frame_done = frame_done_q;

  tetris_row_shifter #(
    .AREA_COL  (AREA_COL),
    .SCLK_HALF (SCLK_HALF)
  ) u_shifter (
    .clk_i  (clk),
    .rstn_i (rstn),
    .load_i (shift_load),
    .data_i (rd_data),
    .sdo_o  (led_sdo),
    .sclk_o (led_sclk),
    .done_o (shift_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // enable is only looked at when a row has fully finished, so a row is never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_FETCH;
      ST_FETCH: if (fetch2_q) state_d = ST_SHIFT;
      ST_SHIFT: if (shift_done) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_HOLD;
      ST_HOLD:  if (hold_last) state_d = enable ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_load = (state_q == ST_FETCH) && fetch2_q;
    led_latch  = (state_q == ST_LATCH);
    led_oe_n   = (state_q != ST_HOLD);
    busy       = (state_q != ST_IDLE);
  end

  // led_row takes the new row on entry to LATCH so it is valid during the latch pulse.
  always_comb begin
    fetch2_d     = (state_q == ST_FETCH) ? ~fetch2_q : 1'b0;
    hold_d       = '0;
    row_d        = row_q;
    led_row_d    = led_row_q;
    frame_done_d = 1'b0;
    if (state_q == ST_SHIFT && shift_done) begin
      led_row_d = row_q;
    end
    if (state_q == ST_HOLD) begin
      hold_d = hold_last ? '0 : hold_q + 1'b1;
      if (hold_last) begin
        row_d        = row_last ? '0 : row_q + 1'b1;
        frame_done_d = row_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch2_q     <= 1'b0;
      hold_q       <= '0;
      row_q        <= '0;
      led_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      fetch2_q     <= fetch2_d;
      hold_q       <= hold_d;
      row_q        <= row_d;
      led_row_q    <= led_row_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
